// File: rtl/alu_arith_seq.sv
// Multi-cycle WIDTH-bit add/subtract, one SLICE-bit chunk per clock, with Z/V/N/C flags.
// Optional compare outputs lt/ltu are enabled by defining ALU_ARITH_CMP_EN.
module alu_arith_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             afn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c
`ifdef ALU_ARITH_CMP_EN
  ,
  output logic             lt,
  output logic             ltu
`endif
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int NSLA = (NSL > 0) ? NSL : 1;
  localparam int IW   = (NSLA > 1) ? $clog2(NSLA) : 1;
  localparam int MSB  = WIDTH - 1;
  localparam logic [IW-1:0] LAST = IW'(NSLA - 1);

  generate
    if (((WIDTH % SLICE) != 0) || (SLICE > WIDTH)) begin : g_bad_params
      $error("alu_arith_seq: WIDTH must be a multiple of SLICE and SLICE <= WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] xb_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic             z_reg, v_reg, n_reg, c_reg;
`ifdef ALU_ARITH_CMP_EN
  logic             afn_reg;
  logic             lt_reg, ltu_reg;
`endif

  // Operands split into slices so the active chunk is a simple array select.
  logic [SLICE-1:0] a_sl  [NSLA];
  logic [SLICE-1:0] xb_sl [NSLA];

  generate
    for (genvar gi = 0; gi < NSLA; gi++) begin : g_slice
      assign a_sl[gi]  = a_reg[gi*SLICE +: SLICE];
      assign xb_sl[gi] = xb_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] s_full;
  logic             last;
  logic             v_full;
  int               slice_base;

  assign last       = (idx_reg == LAST);
  assign slice_base = int'(idx_reg) * SLICE;
  assign slice_sum  = {1'b0, a_sl[idx_reg]} + {1'b0, xb_sl[idx_reg]}
                    + {{SLICE{1'b0}}, carry_reg};

  // Full result including the slice being written this cycle; the flags use it.
  always_comb begin
    s_full = s_reg;
    s_full[slice_base +: SLICE] = slice_sum[SLICE-1:0];
  end

  assign v_full = (a_reg[MSB] & xb_reg[MSB] & ~s_full[MSB])
                | (~a_reg[MSB] & ~xb_reg[MSB] & s_full[MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      xb_reg    <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      z_reg     <= 1'b0;
      v_reg     <= 1'b0;
      n_reg     <= 1'b0;
      c_reg     <= 1'b0;
`ifdef ALU_ARITH_CMP_EN
      afn_reg   <= 1'b0;
      lt_reg    <= 1'b0;
      ltu_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            xb_reg    <= b ^ {WIDTH{afn}};
            carry_reg <= afn;
            idx_reg   <= '0;
`ifdef ALU_ARITH_CMP_EN
            afn_reg   <= afn;
`endif
          end
        end
        CALC: begin
          s_reg     <= s_full;
          carry_reg <= slice_sum[SLICE];
          idx_reg   <= idx_reg + IW'(1);
          if (last) begin
            z_reg <= (s_full == '0);
            n_reg <= s_full[MSB];
            c_reg <= slice_sum[SLICE];
            v_reg <= v_full;
`ifdef ALU_ARITH_CMP_EN
            lt_reg  <= afn_reg & (s_full[MSB] ^ v_full);
            ltu_reg <= afn_reg & ~slice_sum[SLICE];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign s         = s_reg;
  assign z         = z_reg;
  assign v         = v_reg;
  assign n         = n_reg;
  assign c         = c_reg;
`ifdef ALU_ARITH_CMP_EN
  assign lt        = lt_reg;
  assign ltu       = ltu_reg;
`endif

endmodule
